captura_operandos: RTL
======================

CAPTURA_OPERANDOS -- requirements
Module: captura_operandos

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 1000000, sets the consecutive stable cycles required before a key level change is accepted (20 ms at 50 MHz).
REQ-002 CLOCK_50  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 SW  input  18  switches; SW[17:14] operand A, SW[3:0] operand B, SW[10] carry-in TE0.
REQ-005 KEY_ENTRA  input  1  raw pushbutton, active-low, asynchronous and bouncing.
REQ-006 A  output  4  captured operand A.
REQ-007 B  output  4  captured operand B.
REQ-008 TE0  output  1  captured carry-in.
REQ-009 VALIDO  output  1  high while A, B and TE0 form a complete operand set for the adder.
REQ-010 NOVO  output  1  one-cycle strobe marking the cycle a new operand set becomes valid.
REQ-011 LEDG  output  3  one-hot state indicator: [0] ESPERA_A, [1] ESPERA_B, [2] RESULTADO.

Function
REQ-012 KEY_ENTRA SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Filtered key level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CICLOS consecutive cycles; any return to the filtered level SHALL clear the stability counter.
REQ-014 The stability counter SHALL be sized to hold DEBOUNCE_CICLOS and SHALL saturate rather than wrap.
REQ-015 A press pulse SHALL be asserted for exactly one cycle, in the cycle after the filtered level goes 1->0; release and a held key SHALL NOT generate pulses.
REQ-016 FSM states: ESPERA_A, ESPERA_B, RESULTADO; with no press pulse, the state SHALL be held.
REQ-017 ESPERA_A + press: A <= SW[17:14]; next state ESPERA_B.
REQ-018 ESPERA_B + press: B <= SW[3:0], TE0 <= SW[10]; next state RESULTADO.
REQ-019 RESULTADO + press: next state ESPERA_A; A, B and TE0 SHALL be held unchanged.
REQ-020 VALIDO SHALL be high exactly while the state is RESULTADO.
REQ-021 NOVO SHALL be high for exactly the first cycle in RESULTADO after each entry.
REQ-022 SW changes outside a press cycle SHALL NOT affect A, B or TE0.
REQ-023 Latency, raw key edge to LEDG change: 2 synchronizer cycles + DEBOUNCE_CICLOS + 1 pulse cycle + 1 register cycle.
REQ-024 A, B and TE0 are registered outputs with no combinational path from SW or KEY_ENTRA.

Reset
REQ-025 RESET SHALL take priority over a press pulse occurring in the same cycle.
REQ-026 Reset values: A=0, B=0, TE0=0, VALIDO=0, NOVO=0, LEDG=3'b001 (ESPERA_A).
REQ-027 Reset SHALL set the synchronizer flops and the filtered level to 1 (released) and the stability counter to 0.
REQ-028 Reset mid-debounce SHALL discard the pending edge; no pulse SHALL follow reset unless the key is re-pressed and held stable.

Configuration
REQ-029 Macro CAPTURA_DEBOUNCE_EN defined: the filter of REQ-013/014 SHALL be compiled in.
REQ-030 Macro CAPTURA_DEBOUNCE_EN undefined: the filter and counter SHALL be omitted; the filtered level equals the synchronized level, and edge-to-LEDG latency is 4 cycles.

Verification (DEBOUNCE_CICLOS=4, CAPTURA_DEBOUNCE_EN defined unless stated)
REQ-031 Reset, then SW[17:14]=9, press; SW[3:0]=7, SW[10]=1, press -> A=9, B=7, TE0=1, VALIDO=1, NOVO high one cycle, LEDG=100.
REQ-032 KEY_ENTRA toggling every 2 cycles for 20 cycles, then high -> no pulse; LEDG stays 001.
REQ-033 Key held low for 1000 cycles in ESPERA_A -> exactly one transition to ESPERA_B; A captured once.
REQ-034 Press in RESULTADO -> LEDG=001, VALIDO=0, A and B unchanged; change SW without pressing -> outputs unchanged.
REQ-035 RESET asserted in the same cycle as a press pulse in ESPERA_B -> all outputs at reset values, B=0.
REQ-036 Macro undefined: key driven low for a single cycle -> LEDG changes 4 cycles after the edge.

Source files
------------

// File: rtl/captura_operandos.sv
// captura_operandos: captures a 4-bit operand pair and a carry-in for an adder.
// Operands are entered one at a time with a bouncing, active-low pushbutton.
// Optional build macro CAPTURA_DEBOUNCE_EN compiles in the key debounce filter;
// without it the synchronized key level is used directly.
module captura_operandos #(
    parameter int unsigned DEBOUNCE_CICLOS = 1000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [17:0] SW,
    input  logic        KEY_ENTRA,
    output logic [3:0]  A,
    output logic [3:0]  B,
    output logic        TE0,
    output logic        VALIDO,
    output logic        NOVO,
    output logic [2:0]  LEDG
);

    typedef enum logic [1:0] {
        ESPERA_A  = 2'd0,
        ESPERA_B  = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    localparam logic [2:0] LED_ESPERA_A  = 3'b001;
    localparam logic [2:0] LED_ESPERA_B  = 3'b010;
    localparam logic [2:0] LED_RESULTADO = 3'b100;

    logic    key_meta;
    logic    key_sync;
    logic    key_filt;
    logic    key_filt_q;
    logic    pulso_entra;
    estado_t estado;

    // Two-flop synchronizer for the asynchronous pushbutton; resets to released.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values, which is what makes the two-stage chain a chain.
        if (RESET) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= KEY_ENTRA;
            key_sync <= key_meta;
        end
    end

`ifdef CAPTURA_DEBOUNCE_EN
    localparam int unsigned          CNT_W      = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0]     CNT_ULTIMO = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CNT_W-1:0]     CNT_SAT    = CNT_W'(DEBOUNCE_CICLOS);

    logic [CNT_W-1:0] cnt_estavel;

    // Debounce: accept a new level only after it has differed from the filtered
    // level for DEBOUNCE_CICLOS consecutive cycles; any agreement restarts the count.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_filt    <= 1'b1;
            cnt_estavel <= '0;
        end else if (key_sync == key_filt) begin
            cnt_estavel <= '0;
        end else if (cnt_estavel == CNT_ULTIMO) begin
            key_filt    <= key_sync;
            cnt_estavel <= '0;
        end else if (cnt_estavel != CNT_SAT) begin
            cnt_estavel <= cnt_estavel + 1'b1;
        end
    end
`else
    // Without the filter the synchronized level is taken as the clean level.
    assign key_filt = key_sync;
`endif

    // Registered press detector: one pulse the cycle after a 1->0 filtered edge.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            key_filt_q  <= 1'b1;
            pulso_entra <= 1'b0;
        end else begin
            key_filt_q  <= key_filt;
            pulso_entra <= key_filt_q & ~key_filt;
        end
    end

    // Operand capture FSM with registered outputs; reset overrides a same-cycle press.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            // NOTE: every output register is reset here so the adder never sees
            // stale operands flagged as valid after a reset.
            estado <= ESPERA_A;
            A      <= '0;
            B      <= '0;
            TE0    <= 1'b0;
            VALIDO <= 1'b0;
            NOVO   <= 1'b0;
            LEDG   <= LED_ESPERA_A;
        end else begin
            NOVO <= 1'b0;
            if (pulso_entra) begin
                case (estado)
                    ESPERA_A: begin
                        A      <= SW[17:14];
                        estado <= ESPERA_B;
                        LEDG   <= LED_ESPERA_B;
                        VALIDO <= 1'b0;
                    end
                    ESPERA_B: begin
                        B      <= SW[3:0];
                        TE0    <= SW[10];
                        estado <= RESULTADO;
                        LEDG   <= LED_RESULTADO;
                        VALIDO <= 1'b1;
                        NOVO   <= 1'b1;
                    end
                    RESULTADO: begin
                        estado <= ESPERA_A;
                        LEDG   <= LED_ESPERA_A;
                        VALIDO <= 1'b0;
                    end
                    default: begin
                        estado <= ESPERA_A;
                        LEDG   <= LED_ESPERA_A;
                        VALIDO <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
